// File: rtl/mw_hazard_unit_pkg.sv
// Shared definitions for the MW-stage hazard unit: writeback-select encodings,
// memory-wait FSM states and the hardwired-zero register index.
package mw_hazard_unit_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned WB_SEL_W  = 2;

  localparam logic [WB_SEL_W-1:0] WB_ALU = 2'b00;
  localparam logic [WB_SEL_W-1:0] WB_MEM = 2'b01;
  localparam logic [WB_SEL_W-1:0] WB_PC4 = 2'b10;
  localparam logic [WB_SEL_W-1:0] WB_CSR = 2'b11;

  localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mw_hazard_unit_mem_wait_fsm.sv
// Data-memory wait-state tracker: stalls MW while a request is outstanding and
// flags a timeout when the ack never comes within TIMEOUT stalled cycles.
module mw_hazard_unit_mem_wait_fsm
  import mw_hazard_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic dmem_req,
  input  logic dmem_ack,
  output logic mem_stall_c,
  output logic timeout_pulse_c
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  mem_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // An ack always wins over the timeout in the same cycle.
  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    mem_stall_c     = 1'b0;
    timeout_pulse_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (dmem_req && !dmem_ack) begin
          mem_stall_c = 1'b1;
          state_d     = ST_MEM_WAIT;
          wait_cnt_d  = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        mem_stall_c = !dmem_ack;
        if (dmem_ack) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_pulse_c = 1'b1;
          state_d         = ST_RUN;
          wait_cnt_d      = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/mw_hazard_unit.sv
// Hazard control for the MW stage of the 3-stage RV32I pipeline: operand
// forwarding, memory-wait stalls, branch/timeout flushes and a stall counter.
module mw_hazard_unit
  import mw_hazard_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rs1_F,
  input  logic [REG_IDX_W-1:0] rs2_F,
  input  logic [REG_IDX_W-1:0] rd_MW,
  input  logic                 reg_wrMW,
  input  logic [WB_SEL_W-1:0]  wb_selMW,
  input  logic                 csr_reg_rdMW,
  input  logic                 br_taken,
  input  logic                 dmem_req,
  input  logic                 dmem_ack,
  output logic                 fwd_a,
  output logic                 fwd_b,
  output logic                 Stall_IF,
  output logic                 Stall_MW,
  output logic                 Flush_IF,
  output logic                 Flush_MW,
  output logic                 bus_err,
  output logic [CNT_W-1:0]     stall_cnt
);

  logic mem_stall_c;
  logic timeout_pulse_c;
  logic wb_valid_c;
  logic fwd_src_c;
  logic br_flush_c;

  mw_hazard_unit_mem_wait_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_mem_wait_fsm (
    .clk             (clk),
    .rst             (rst),
    .dmem_req        (dmem_req),
    .dmem_ack        (dmem_ack),
    .mem_stall_c     (mem_stall_c),
    .timeout_pulse_c (timeout_pulse_c)
  );

  // A CSR writeback only carries a value when the instruction actually read the CSR.
  always_comb begin
    wb_valid_c = (wb_selMW != WB_CSR) || csr_reg_rdMW;
    fwd_src_c  = !rst && reg_wrMW && wb_valid_c && (rd_MW != REG_X0) && !mem_stall_c;
    fwd_a      = fwd_src_c && (rd_MW == rs1_F);
    fwd_b      = fwd_src_c && (rd_MW == rs2_F);
  end

  // A taken branch seen during a stall is simply re-evaluated once the stall lifts.
  always_comb begin
    br_flush_c = br_taken && !mem_stall_c;
    Stall_IF   = !rst && mem_stall_c;
    Stall_MW   = !rst && mem_stall_c;
    Flush_IF   = !rst && br_flush_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Flush_MW <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      Flush_MW <= br_flush_c || timeout_pulse_c;
      bus_err  <= timeout_pulse_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (Stall_MW && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mw_hazard_unit.sv
// Directed self-checking bench for mw_hazard_unit (TIMEOUT=4), with a second
// narrow-counter instance to exercise stall_cnt saturation.
module tb_mw_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_F, rs2_F, rd_MW;
  logic       reg_wrMW;
  logic [1:0] wb_selMW;
  logic       csr_reg_rdMW, br_taken, dmem_req, dmem_ack;

  logic        fwd_a, fwd_b, Stall_IF, Stall_MW, Flush_IF, Flush_MW, bus_err;
  logic [31:0] stall_cnt;

  logic        s_fwd_a, s_fwd_b, s_stall_if, s_stall_mw, s_flush_if, s_flush_mw, s_bus_err;
  logic [1:0]  s_stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  mw_hazard_unit #(.TIMEOUT(4), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .rs1_F(rs1_F), .rs2_F(rs2_F), .rd_MW(rd_MW),
    .reg_wrMW(reg_wrMW), .wb_selMW(wb_selMW), .csr_reg_rdMW(csr_reg_rdMW),
    .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .Stall_IF(Stall_IF), .Stall_MW(Stall_MW),
    .Flush_IF(Flush_IF), .Flush_MW(Flush_MW), .bus_err(bus_err), .stall_cnt(stall_cnt)
  );

  mw_hazard_unit #(.TIMEOUT(4), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .rs1_F(rs1_F), .rs2_F(rs2_F), .rd_MW(rd_MW),
    .reg_wrMW(reg_wrMW), .wb_selMW(wb_selMW), .csr_reg_rdMW(csr_reg_rdMW),
    .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .Stall_IF(s_stall_if), .Stall_MW(s_stall_mw),
    .Flush_IF(s_flush_if), .Flush_MW(s_flush_mw), .bus_err(s_bus_err), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 unit later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_stall(input string tag, input logic exp);
    check({tag, "_stall_mw"}, 32'(Stall_MW), 32'(exp));
    check({tag, "_stall_if"}, 32'(Stall_IF), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    rs1_F = 5'd5; rs2_F = 5'd5; rd_MW = 5'd5; reg_wrMW = 1'b1;
    wb_selMW = 2'b00; csr_reg_rdMW = 1'b0; br_taken = 1'b1;
    dmem_req = 1'b1; dmem_ack = 1'b0;

    // Reset: combinational outputs forced low even with hazard-looking inputs
    step(); settle();
    check("rst_fwd_a", 32'(fwd_a), 32'd0);
    check("rst_fwd_b", 32'(fwd_b), 32'd0);
    check_stall("rst", 1'b0);
    check("rst_flush_if", 32'(Flush_IF), 32'd0);
    check("rst_flush_mw", 32'(Flush_MW), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    br_taken = 1'b0; dmem_req = 1'b0;
    rst = 1'b0;

    // Forwarding patterns
    step(); rs1_F = 5'd5; rs2_F = 5'd6; rd_MW = 5'd5; settle();
    check("fwd_rs1_a", 32'(fwd_a), 32'd1);
    check("fwd_rs1_b", 32'(fwd_b), 32'd0);
    rd_MW = 5'd0; rs1_F = 5'd0; settle();
    check("fwd_x0_a", 32'(fwd_a), 32'd0);
    rd_MW = 5'd7; rs1_F = 5'd7; rs2_F = 5'd7; wb_selMW = 2'b11; csr_reg_rdMW = 1'b0; settle();
    check("fwd_csr_nord_a", 32'(fwd_a), 32'd0);
    check("fwd_csr_nord_b", 32'(fwd_b), 32'd0);
    csr_reg_rdMW = 1'b1; settle();
    check("fwd_csr_rd_a", 32'(fwd_a), 32'd1);
    check("fwd_csr_rd_b", 32'(fwd_b), 32'd1);
    wb_selMW = 2'b01; reg_wrMW = 1'b0; settle();
    check("fwd_nowr_a", 32'(fwd_a), 32'd0);
    reg_wrMW = 1'b1; rs1_F = 5'd3; settle();
    check("fwd_load_b", 32'(fwd_b), 32'd1);
    check("fwd_load_a", 32'(fwd_a), 32'd0);

    // Single-cycle memory access
    step(); rd_MW = 5'd5; rs1_F = 5'd5; rs2_F = 5'd6; wb_selMW = 2'b00;
    dmem_req = 1'b1; dmem_ack = 1'b1; settle();
    check_stall("mem1", 1'b0);
    check("mem1_fwd_a", 32'(fwd_a), 32'd1);
    step(); dmem_req = 1'b0; dmem_ack = 1'b0; settle();
    check("mem1_cnt", stall_cnt, 32'd0);

    // Wait states: ack three cycles after the request
    step(); dmem_req = 1'b1; settle();
    check_stall("ws0", 1'b1);
    check("ws0_fwd_a", 32'(fwd_a), 32'd0);
    step(); settle();
    check_stall("ws1", 1'b1);
    step(); settle();
    check_stall("ws2", 1'b1);
    check("ws2_fwd_a", 32'(fwd_a), 32'd0);
    step(); dmem_ack = 1'b1; settle();
    check_stall("ws_ack", 1'b0);
    check("ws_ack_fwd_a", 32'(fwd_a), 32'd1);
    check("ws_ack_cnt", stall_cnt, 32'd3);
    step(); dmem_req = 1'b0; dmem_ack = 1'b0; settle();
    check("ws_post_cnt", stall_cnt, 32'd3);
    check("ws_post_bus_err", 32'(bus_err), 32'd0);
    check("ws_post_flush_mw", 32'(Flush_MW), 32'd0);

    // Timeout after four stalled cycles
    step(); dmem_req = 1'b1; settle();
    check_stall("to0", 1'b1);
    for (int i = 1; i < 4; i++) begin
      step(); settle();
      check_stall($sformatf("to%0d", i), 1'b1);
      check($sformatf("to%0d_bus_err", i), 32'(bus_err), 32'd0);
    end
    step(); dmem_req = 1'b0; settle();
    check("to_bus_err", 32'(bus_err), 32'd1);
    check("to_flush_mw", 32'(Flush_MW), 32'd1);
    check_stall("to_run", 1'b0);
    check("to_cnt", stall_cnt, 32'd7);
    step(); settle();
    check("to_bus_err_once", 32'(bus_err), 32'd0);
    check("to_flush_mw_once", 32'(Flush_MW), 32'd0);

    // Branch taken without a stall
    step(); br_taken = 1'b1; settle();
    check("br_flush_if", 32'(Flush_IF), 32'd1);
    step(); br_taken = 1'b0; settle();
    check("br_flush_mw", 32'(Flush_MW), 32'd1);
    check("br_flush_if_off", 32'(Flush_IF), 32'd0);

    // Branch deferred by a memory stall
    step(); dmem_req = 1'b1; br_taken = 1'b1; settle();
    check("brs0_flush_if", 32'(Flush_IF), 32'd0);
    check_stall("brs0", 1'b1);
    step(); settle();
    check("brs1_flush_if", 32'(Flush_IF), 32'd0);
    check("brs1_flush_mw", 32'(Flush_MW), 32'd0);
    step(); dmem_ack = 1'b1; settle();
    check("brs_ack_flush_if", 32'(Flush_IF), 32'd1);
    check_stall("brs_ack", 1'b0);
    step(); dmem_req = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0; settle();
    check("brs_flush_mw", 32'(Flush_MW), 32'd1);
    check("brs_cnt", stall_cnt, 32'd9);
    check("sat_cnt", 32'(s_stall_cnt), 32'd3);

    // Asynchronous reset while waiting on memory
    step(); dmem_req = 1'b1; settle();
    check_stall("ar0", 1'b1);
    step(); settle();
    check_stall("ar1", 1'b1);
    #2 rst = 1'b1;
    #1;
    check_stall("ar_rst", 1'b0);
    check("ar_rst_fwd_a", 32'(fwd_a), 32'd0);
    check("ar_rst_cnt", stall_cnt, 32'd0);
    check("ar_rst_bus_err", 32'(bus_err), 32'd0);
    check("ar_rst_flush_mw", 32'(Flush_MW), 32'd0);
    step(); rst = 1'b0; dmem_ack = 1'b1; settle();
    check_stall("ar_rel", 1'b0);
    check("ar_rel_fwd_a", 32'(fwd_a), 32'd1);
    step(); dmem_req = 1'b0; dmem_ack = 1'b0; settle();
    check("ar_rel_cnt", stall_cnt, 32'd0);
    check("ar_rel_bus_err", 32'(bus_err), 32'd0);
    check("ar_rel_flush_mw", 32'(Flush_MW), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mw_hazard_unit.md
Name: mw_hazard_unit

Overview:
Consumes the MW-stage control registered by the Fetch-to-MW pipeline register (reg_wrMW, wb_selMW, csr_reg_rdMW, rd) and generates the signals that register and the fetch stage obey. Outputs are operand-forwarding selects, Stall_IF/Stall_MW, fetch/MW flushes, and a data-memory wait-state handshake with timeout. Sits beside the 3-stage RV32I datapath. Its Stall_MW output drives the hold input of the MW pipeline register.

Parameters:
TIMEOUT, 16, max MEM_WAIT cycles before bus error (>=2)
CNT_W, 32, width of stall-cycle performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
rs1_F  in  5  InstF[19:15] of instruction entering MW
rs2_F  in  5  InstF[24:20]
rd_MW  in  5  destination of instruction in MW
reg_wrMW  in  1  MW instruction writes register file
wb_selMW  in  2  00 ALU, 01 load data, 10 PC+4, 11 CSR
csr_reg_rdMW  in  1  MW instruction reads CSR
br_taken  in  1  branch/jump resolved taken in MW
dmem_req  in  1  MW issues load/store this cycle
dmem_ack  in  1  data memory completes request
fwd_a  out  1  forward MW writeback to operand A
fwd_b  out  1  forward MW writeback to operand B
Stall_IF  out  1  hold PC and fetch
Stall_MW  out  1  hold MW pipeline register
Flush_IF  out  1  squash fetched instruction
Flush_MW  out  1  insert bubble into MW register (zero control)
bus_err  out  1  one-cycle pulse on memory timeout
stall_cnt  out  CNT_W  cycles Stall_MW was high, saturating

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - rst is asynchronous and active-high.
  - While rst is high: FSM = RUN, wait counter = 0, stall_cnt = 0, Flush_MW = 0, bus_err = 0.
  - While rst is high, all combinational outputs (fwd_a, fwd_b, Stall_IF, Stall_MW, Flush_IF) are forced to 0.
- Forwarding (combinational):
  - fwd_a = reg_wrMW & (rd_MW != 0) & (rd_MW == rs1_F) & !mem_stall.
  - fwd_b is the same with rs2_F.
  - x0 never forwards.
  - wb_selMW == 11 forwards only if csr_reg_rdMW = 1. Otherwise both fwd outputs are 0 for that case.
- FSM states RUN, MEM_WAIT; mem_stall is the combinational stall term:
  - RUN:
    - dmem_req & !dmem_ack -> mem_stall = 1; next MEM_WAIT; wait counter <= 1.
    - dmem_req & dmem_ack -> no stall; stay RUN.
  - MEM_WAIT:
    - mem_stall = !dmem_ack.
    - dmem_ack -> RUN the same cycle; stalls drop in the ack cycle.
    - Otherwise the wait counter increments.
    - When the counter == TIMEOUT-1 and no ack: bus_err <= 1 for exactly one cycle, Flush_MW <= 1 next cycle, next RUN.
    - dmem_ack in the same cycle as the timeout takes priority: normal completion, no bus_err.
  - dmem_req while in MEM_WAIT is ignored; the request is held by the stall.
- Stall_IF = Stall_MW = mem_stall.
- Branch flush:
  - Flush_IF = br_taken & !mem_stall (combinational).
  - Flush_MW (registered) <= br_taken & !mem_stall, or the timeout condition.
  - br_taken coincident with a stall is deferred. It is re-evaluated each cycle, since br_taken is held by the stalled MW register.
  - Flush and stall are never asserted together.
- stall_cnt:
  - Increments on each clock edge with Stall_MW = 1.
  - Saturates at all-ones and does not wrap.
- Reset mid-MEM_WAIT: immediate return to RUN; no bus_err emitted.

Decomposition:
- Shared package holds:
  - wb_sel encoding constants: WB_ALU, WB_MEM, WB_PC4, WB_CSR.
  - The FSM state enum.
  - The x0 register-index constant.
- One sub-module, mem_wait_fsm, holds the RUN/MEM_WAIT FSM, wait counter and timeout. It outputs mem_stall and timeout_pulse.
- Forwarding logic, flush logic and stall_cnt stay in the top level.

Test Plan:
- Forwarding: reg_wrMW=1, rd_MW=5, rs1_F=5, rs2_F=6, wb_selMW=00 -> fwd_a=1, fwd_b=0. rd_MW=0, rs1_F=0 -> fwd_a=0.
- Single-cycle memory: dmem_req=1, dmem_ack=1 -> Stall_MW=0, FSM stays RUN, stall_cnt unchanged.
- Wait states: dmem_req=1, ack arrives 3 cycles later -> Stall_IF/Stall_MW high for 3 cycles, low in the ack cycle, stall_cnt=3, fwd_a suppressed while stalled.
- Timeout: TIMEOUT=4, dmem_req=1, no ack -> stall for 4 cycles, bus_err pulses once, Flush_MW=1 the following cycle, FSM=RUN.
- Branch during stall: br_taken=1 while in MEM_WAIT -> Flush_IF=0. After ack with br_taken still 1 -> Flush_IF=1 that cycle, Flush_MW=1 next cycle.
- Async reset mid-wait: assert rst between edges in MEM_WAIT -> all outputs 0 immediately, stall_cnt=0. After release, dmem_req with ack behaves as from RUN.
